// File: rtl/axi_ready_gen_pkg.sv
// Purpose : shared types, constants and LFSR helpers for the AXI ready-policy generator.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
// Contents: ready_mode_t (per-channel policy), ch_state_t (per-channel FSM state),
//           LFSR_TAPS / LFSR_DEFAULT_SEED, lfsr_next() and rotl16() helpers.
package axi_ready_gen_pkg;

   typedef enum logic [1:0] {
      MODE_NO_BP  = 2'd0,
      MODE_SINGLE = 2'd1,
      MODE_OSC    = 2'd2,
      MODE_RANDOM = 2'd3
   } ready_mode_t;

   typedef enum logic {
      ST_HIGH = 1'b0,
      ST_LOW  = 1'b1
   } ch_state_t;

   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // One step of a right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

   // Rotate left by k (k < 16); gives each channel a decorrelated view of the one LFSR.
   function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned k);
      return (v << k) | (v >> (16 - k));
   endfunction

endpackage

// File: rtl/axi_ready_ch_fsm.sv
// Purpose : one channel of the ready-policy generator: READY register, policy FSM, handshake counter.
// Latency : ready_o is registered; restart_i takes effect on ready_o at the edge it is sampled.
// Backpressure : none consumed; this block *is* the backpressure source (ready_o) for one channel.
// Ports   : clk_i/rst_ni (sync, active-low), hold_i (freeze for the config-capture cycle),
//           restart_i (restart with freshly captured config), mode_i, low_time_i, high_time_i,
//           rnd_i (this channel's LFSR slice), valid_i, ready_o, hs_cnt_o.
module axi_ready_ch_fsm
   import axi_ready_gen_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int HS_CNT_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                hold_i,
   input  logic                restart_i,
   input  logic [1:0]          mode_i,
   input  logic [CNT_W-1:0]    low_time_i,
   input  logic [CNT_W-1:0]    high_time_i,
   input  logic [CNT_W-1:0]    rnd_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic [HS_CNT_W-1:0] hs_cnt_o
);

   ch_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic [HS_CNT_W-1:0]   hs_cnt_q, hs_cnt_d;
   logic                  hs;
   ready_mode_t           mode;
   logic [CNT_W-1:0]      osc_low, osc_high;

   assign mode = ready_mode_t'(mode_i);
   assign hs   = valid_i & ready_q;

   // Zero-length oscillator phases are stretched to one cycle so OSC never stalls.
   assign osc_low  = (low_time_i  == '0) ? CNT_W'(1) : low_time_i;
   assign osc_high = (high_time_i == '0) ? CNT_W'(1) : high_time_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      // Handshakes are always counted, including during hold/restart cycles.
      hs_cnt_d = hs_cnt_q + HS_CNT_W'(hs);

      if (restart_i) begin
         // Restart beats any pending transition (e.g. a handshake on this same edge).
         if (mode == MODE_OSC) begin
            state_d = ST_LOW;
            cnt_d   = osc_low;
         end else begin
            state_d = ST_HIGH;
            cnt_d   = '0;
         end
      end else if (!hold_i) begin
         case (mode)
            MODE_SINGLE: begin
               if (state_q == ST_HIGH) begin
                  // low_time 0 keeps READY up through back-to-back handshakes.
                  if (hs && (low_time_i != '0)) begin
                     state_d = ST_LOW;
                     cnt_d   = low_time_i;
                  end
               end else if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_HIGH;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            MODE_OSC: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
                  cnt_d   = (state_q == ST_LOW) ? osc_high : osc_low;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end

      // During the capture cycle READY is frozen so old and new configs never mix.
      if (restart_i || !hold_i) begin
         case (mode)
            MODE_NO_BP:            ready_d = 1'b1;
            MODE_SINGLE, MODE_OSC: ready_d = (state_d == ST_HIGH);
            default:               ready_d = (rnd_i >= low_time_i);
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_HIGH;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         hs_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         hs_cnt_q <= hs_cnt_d;
      end
   end

   assign ready_o  = ready_q;
   assign hs_cnt_o = hs_cnt_q;

endmodule

// File: rtl/axi_ready_policy_gen.sv
// Purpose : programmable READY generator for up to 8 AXI channels (AW, W, B, AR, R order).
// Latency : cfg_load captured on its edge, new policy visible on ready_out one edge later.
// Backpressure : drives READY per channel; counts valid_in & ready_out handshakes in hs_cnt.
// Ports   : aclk, aresetn (sync, active-low), cfg_load/cfg_mode/cfg_low_time/cfg_high_time/
//           cfg_seed (config, captured on cfg_load), valid_in, ready_out, hs_cnt.
module axi_ready_policy_gen
   import axi_ready_gen_pkg::*;
#(
   parameter int NUM_CH   = 5,   // 1..8
   parameter int CNT_W    = 8,
   parameter int HS_CNT_W = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       cfg_load,
   input  logic [2*NUM_CH-1:0]        cfg_mode,
   input  logic [CNT_W*NUM_CH-1:0]    cfg_low_time,
   input  logic [CNT_W*NUM_CH-1:0]    cfg_high_time,
   input  logic [15:0]                cfg_seed,
   input  logic [NUM_CH-1:0]          valid_in,
   output logic [NUM_CH-1:0]          ready_out,
   output logic [HS_CNT_W*NUM_CH-1:0] hs_cnt
);

   logic [2*NUM_CH-1:0]     mode_q, mode_d;
   logic [CNT_W*NUM_CH-1:0] low_q, low_d;
   logic [CNT_W*NUM_CH-1:0] high_q, high_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic                    load_q;

   always_comb begin
      mode_d = mode_q;
      low_d  = low_q;
      high_d = high_q;
      lfsr_d = lfsr_next(lfsr_q);
      if (cfg_load) begin
         mode_d = cfg_mode;
         low_d  = cfg_low_time;
         high_d = cfg_high_time;
         // An all-zero seed would lock the LFSR up.
         lfsr_d = (cfg_seed == 16'h0000) ? LFSR_DEFAULT_SEED : cfg_seed;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         mode_q <= '0;
         low_q  <= '0;
         high_q <= '0;
         lfsr_q <= LFSR_DEFAULT_SEED;
         load_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         low_q  <= low_d;
         high_q <= high_d;
         lfsr_q <= lfsr_d;
         // Channels restart one edge after capture, once the new config is registered.
         load_q <= cfg_load;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] rnd;
      assign rnd = CNT_W'(rotl16(lfsr_q, 2 * c));

      axi_ready_ch_fsm #(
         .CNT_W    (CNT_W),
         .HS_CNT_W (HS_CNT_W)
      ) u_ch (
         .clk_i       (aclk),
         .rst_ni      (aresetn),
         .hold_i      (cfg_load),
         .restart_i   (load_q),
         .mode_i      (mode_q[2*c +: 2]),
         .low_time_i  (low_q[CNT_W*c +: CNT_W]),
         .high_time_i (high_q[CNT_W*c +: CNT_W]),
         .rnd_i       (rnd),
         .valid_i     (valid_in[c]),
         .ready_o     (ready_out[c]),
         .hs_cnt_o    (hs_cnt[HS_CNT_W*c +: HS_CNT_W])
      );
   end

endmodule

// File: tb/tb_axi_ready_policy_gen.sv
// Purpose : self-checking bench for axi_ready_policy_gen (directed scenarios + random traffic).
// Latency : n/a.
// Backpressure : n/a.
`timescale 1ns/1ps
module tb_axi_ready_policy_gen;

   localparam int NUM_CH   = 5;
   localparam int CNT_W    = 8;
   localparam int HS_CNT_W = 16;

   logic                       aclk = 1'b0;
   logic                       aresetn;
   logic                       cfg_load;
   logic [2*NUM_CH-1:0]        cfg_mode;
   logic [CNT_W*NUM_CH-1:0]    cfg_low_time;
   logic [CNT_W*NUM_CH-1:0]    cfg_high_time;
   logic [15:0]                cfg_seed;
   logic [NUM_CH-1:0]          valid_in;
   logic [NUM_CH-1:0]          ready_out;
   logic [HS_CNT_W*NUM_CH-1:0] hs_cnt;

   axi_ready_policy_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HS_CNT_W(HS_CNT_W)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg_load      (cfg_load),
      .cfg_mode      (cfg_mode),
      .cfg_low_time  (cfg_low_time),
      .cfg_high_time (cfg_high_time),
      .cfg_seed      (cfg_seed),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .hs_cnt        (hs_cnt)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model (behavioural, edge by edge) ----------------
   function automatic logic [15:0] ref_step(input logic [15:0] x);
      if (x % 2 == 1) return (x / 2) ^ 16'hB400;
      return x / 2;
   endfunction

   function automatic int ref_slice(input logic [15:0] x, input int c);
      logic [31:0] w;
      w = {16'h0000, x};
      w = ((w << (2 * c)) | (w >> (16 - 2 * c))) & 32'h0000_FFFF;
      return int'(w % 256);
   endfunction

   int                m_cyc = 0;
   logic [15:0]       m_lfsr;
   logic [NUM_CH-1:0] m_rdy, m_nxt;
   bit                m_pend, m_hold, m_hs;
   int m_mode[NUM_CH], m_low[NUM_CH], m_high[NUM_CH];
   int m_blk[NUM_CH];   // SINGLE: ready is 0 up to and including this edge index
   int m_t0[NUM_CH];    // OSC: edge index of the last restart
   int m_hs_cnt[NUM_CH];
   int lo1, hi1;

   always @(posedge aclk) begin
      #1;
      m_cyc++;
      if (!aresetn) begin
         m_rdy  = '0;
         m_lfsr = 16'hACE1;
         m_pend = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_low[c] = 0; m_high[c] = 0;
            m_blk[c] = -1; m_t0[c] = 0; m_hs_cnt[c] = 0;
         end
      end else begin
         m_hold = cfg_load && !m_pend;
         for (int c = 0; c < NUM_CH; c++) begin
            m_hs = valid_in[c] && m_rdy[c];
            if (m_hs) m_hs_cnt[c] = (m_hs_cnt[c] + 1) % 65536;
            if (m_pend) begin
               m_blk[c] = -1;
               m_t0[c]  = m_cyc;
            end else if (!m_hold && m_hs && m_mode[c] == 1) begin
               m_blk[c] = m_cyc + m_low[c] - 1;
            end
            lo1 = (m_low[c]  == 0) ? 1 : m_low[c];
            hi1 = (m_high[c] == 0) ? 1 : m_high[c];
            if (m_hold)              m_nxt[c] = m_rdy[c];
            else if (m_mode[c] == 0) m_nxt[c] = 1'b1;
            else if (m_mode[c] == 1) m_nxt[c] = (m_cyc > m_blk[c]);
            else if (m_mode[c] == 2) m_nxt[c] = (((m_cyc - m_t0[c]) % (lo1 + hi1)) >= lo1);
            else                     m_nxt[c] = (ref_slice(m_lfsr, c) >= m_low[c]);
         end
         if (cfg_load) begin
            for (int c = 0; c < NUM_CH; c++) begin
               m_mode[c] = int'(cfg_mode[2*c +: 2]);
               m_low[c]  = int'(cfg_low_time[CNT_W*c +: CNT_W]);
               m_high[c] = int'(cfg_high_time[CNT_W*c +: CNT_W]);
            end
            m_lfsr = (cfg_seed == 16'h0) ? 16'hACE1 : cfg_seed;
         end else begin
            m_lfsr = ref_step(m_lfsr);
         end
         m_pend = cfg_load;
         m_rdy  = m_nxt;
      end
      chk("model_ready", ready_out, m_rdy);
      for (int c = 0; c < NUM_CH; c++)
         chk("model_hs_cnt", hs_cnt[HS_CNT_W*c +: HS_CNT_W], m_hs_cnt[c]);
   end

   // ---------------- stimulus ----------------
   task automatic load_cfg(input logic [2*NUM_CH-1:0] md, input logic [CNT_W*NUM_CH-1:0] lo,
                           input logic [CNT_W*NUM_CH-1:0] hi, input logic [15:0] sd);
      cfg_mode = md; cfg_low_time = lo; cfg_high_time = hi; cfg_seed = sd;
      cfg_load = 1'b1;
      @(negedge aclk);
      cfg_load = 1'b0;
      @(negedge aclk);
   endtask

   bit exp_single[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
   bit exp_osc[10]   = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
   int rlow[NUM_CH]  = '{8'h80, 8'h00, 8'hFF, 8'h40, 8'hC0};
   int h0, h4, gap, md;
   logic [15:0]       lf;
   logic [NUM_CH-1:0] ev;

   task automatic check_random_run(input string tag);
      lf = 16'hACE1;
      for (int i = 0; i < 20; i++) begin
         for (int c = 0; c < NUM_CH; c++) ev[c] = (ref_slice(lf, c) >= rlow[c]);
         chk(tag, ready_out, ev);
         chk("rnd_low0_const", ready_out[1], 1);
         lf = ref_step(lf);
         valid_in = NUM_CH'($urandom);
         @(negedge aclk);
      end
   endtask

   initial begin
      aresetn = 1'b0; cfg_load = 1'b0; cfg_mode = '0; cfg_low_time = '0;
      cfg_high_time = '0; cfg_seed = '0; valid_in = '1;
      repeat (3) @(negedge aclk);
      chk("reset_ready", ready_out, 0);
      chk("reset_hs0", hs_cnt[15:0], 0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("release_ready", ready_out, 5'h1F);
      chk("release_hs0", hs_cnt[15:0], 0);
      repeat (6) @(negedge aclk);
      chk("nobp_hs0", hs_cnt[15:0], 6);
      chk("nobp_hs4", hs_cnt[79:64], 6);

      // SINGLE, low_time 3 on ch0, valid held
      load_cfg(10'h001, 40'h03, 40'h0, 16'h0);
      h0 = int'(hs_cnt[15:0]);
      for (int i = 0; i < 8; i++) begin
         chk("single_pattern", ready_out[0], exp_single[i]);
         @(negedge aclk);
      end
      chk("single_hs_delta", hs_cnt[15:0] - 16'(h0), 2);

      // OSC low 2 / high 3 on ch4, no valid
      valid_in = '0;
      load_cfg(10'h200, {8'd2, 32'h0}, {8'd3, 32'h0}, 16'h0);
      h4 = int'(hs_cnt[79:64]);
      for (int i = 0; i < 10; i++) begin
         chk("osc_pattern", ready_out[4], exp_osc[i]);
         @(negedge aclk);
      end
      chk("osc_hs_stuck", hs_cnt[79:64], h4);

      // RANDOM: seed 0 and seed ACE1 must both follow the ACE1 sequence
      load_cfg(10'h3FF, {8'hC0, 8'h40, 8'hFF, 8'h00, 8'h80}, 40'h0, 16'h0000);
      check_random_run("rnd_seed0");
      load_cfg(10'h3FF, {8'hC0, 8'h40, 8'hFF, 8'h00, 8'h80}, 40'h0, 16'hACE1);
      check_random_run("rnd_seedace1");

      // SINGLE low 5: cfg_load on a handshake edge, then mid-LOW reload, then mid-LOW reset
      valid_in = '1;
      load_cfg(10'h001, 40'h05, 40'h0, 16'h0);
      h0 = int'(hs_cnt[15:0]);
      load_cfg(10'h001, 40'h05, 40'h0, 16'h0);
      chk("load_on_hs_ready", ready_out[0], 1);
      chk("load_on_hs_count", hs_cnt[15:0] - 16'(h0), 2);
      @(negedge aclk);
      chk("single_low_entry", ready_out[0], 0);
      @(negedge aclk);
      cfg_load = 1'b1;
      @(negedge aclk);
      chk("midlow_load_hold", ready_out[0], 0);
      cfg_load = 1'b0;
      @(negedge aclk);
      chk("midlow_load_restart", ready_out[0], 1);
      @(negedge aclk);
      chk("single_low_again", ready_out[0], 0);
      aresetn = 1'b0;
      @(negedge aclk);
      chk("midlow_reset_ready", ready_out[0], 0);
      chk("midlow_reset_hs", hs_cnt[15:0], 0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("midlow_release_ready", ready_out, 5'h1F);

      // Random traffic, configs and resets, checked by the model
      gap = 0;
      for (int i = 0; i < 600; i++) begin
         valid_in = NUM_CH'($urandom);
         if (gap == 0 && $urandom_range(0, 9) == 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
               md = int'($urandom_range(0, 3));
               cfg_mode[2*c +: 2] = 2'(md);
               cfg_low_time[CNT_W*c +: CNT_W]  = (md == 3) ? 8'($urandom_range(0, 255))
                                                           : 8'($urandom_range(0, 5));
               cfg_high_time[CNT_W*c +: CNT_W] = 8'($urandom_range(0, 5));
            end
            cfg_seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cfg_load = 1'b1;
            gap = 2;
         end else begin
            cfg_load = 1'b0;
            if (gap > 0) gap--;
         end
         aresetn = ($urandom_range(0, 59) != 0);
         @(negedge aclk);
      end
      cfg_load = 1'b0;

      // Handshake counter wrap
      aresetn = 1'b0;
      valid_in = '1;
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("wrap_start", hs_cnt[15:0], 0);
      repeat (65535) @(negedge aclk);
      chk("wrap_ffff_ch0", hs_cnt[15:0], 16'hFFFF);
      chk("wrap_ffff_ch3", hs_cnt[63:48], 16'hFFFF);
      @(negedge aclk);
      chk("wrap_zero_ch0", hs_cnt[15:0], 0);
      chk("wrap_zero_ch4", hs_cnt[79:64], 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
